vx_tex_mem_responder: RTL and testbench
=======================================

VX_TEX_MEM_RESPONDER -- requirements
Module: VX_tex_mem_responder

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of independent request/response channels, matching TCACHE_NUM_REQS.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12: word address width; MEM_WORDS = 2^ADDR_WIDTH 32-bit words.
REQ-003 SHALL have parameter TAG_WIDTH, default 8: opaque per-request tag width.
REQ-004 SHALL have parameter LATENCY, default 2, legal range 1..4: fixed read pipeline depth in cycles.
REQ-005 SHALL have parameter QUEUE_SIZE, default 4, power of two, at least LATENCY: maximum outstanding reads per channel.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port req_valid, input, [NUM_REQS]: per-channel request valid.
REQ-009 SHALL have port req_rw, input, [NUM_REQS]: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, [NUM_REQS][ADDR_WIDTH]: word address.
REQ-011 SHALL have port req_byteen, input, [NUM_REQS][4]: write byte enables; ignored on reads.
REQ-012 SHALL have port req_data, input, [NUM_REQS][32]: write data.
REQ-013 SHALL have port req_tag, input, [NUM_REQS][TAG_WIDTH]: request tag.
REQ-014 SHALL have port req_ready, output, [NUM_REQS]: per-channel request ready.
REQ-015 SHALL have port rsp_valid, output, [NUM_REQS]: per-channel read response valid.
REQ-016 SHALL have port rsp_data, output, [NUM_REQS][32]: read word.
REQ-017 SHALL have port rsp_tag, output, [NUM_REQS][TAG_WIDTH]: tag of the originating read.
REQ-018 SHALL have port rsp_ready, input, [NUM_REQS]: per-channel response ready.

Function
REQ-019 SHALL accept a request on channel i when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-020 SHALL drive req_ready[i] high for writes unconditionally, and high for reads only while pending[i] < QUEUE_SIZE.
REQ-021 SHALL decode req_ready[i] from registered state and req_rw[i] only, with no combinational path from rsp_ready.
REQ-022 SHALL keep a per-channel pending counter: +1 on an accepted read, -1 on response fire (rsp_valid & rsp_ready), unchanged when both occur in the same cycle.
REQ-023 SHALL apply an accepted write at the clock edge, updating only the bytes selected by req_byteen; a write SHALL produce no response.
REQ-024 SHALL resolve same-cycle writes to the same word from several channels per byte, with the highest channel index taking precedence.
REQ-025 SHALL return old data (read-before-write) for a read in the same cycle as a write to the same word; a read accepted one or more cycles after the write SHALL return the new data.
REQ-026 SHALL sample the memory for an accepted read in its acceptance cycle T, then carry data and tag through a LATENCY-stage valid pipeline into a per-channel FIFO of depth QUEUE_SIZE.
REQ-027 SHALL assert rsp_valid no earlier than cycle T+LATENCY, and exactly at T+LATENCY when the channel FIFO is empty and rsp_ready is high.
REQ-028 SHALL return responses on each channel in acceptance order, with no ordering relation between channels.
REQ-029 SHALL hold rsp_valid, rsp_data and rsp_tag stable while rsp_valid is high and rsp_ready is low.
REQ-030 SHALL never overflow the FIFO: the pending limit guarantees space for every read still in the pipeline.
REQ-031 SHALL allow a full FIFO to accept a pipeline entry in the same cycle that an entry is popped.
REQ-032 SHALL serve reads from multiple channels to the same word in the same cycle independently, each returning identical data.

Reset
REQ-033 SHALL, while reset is high, clear all pending counters, pipeline valid bits and FIFO pointers, drive rsp_valid to 0, and drive req_ready to 1.
REQ-034 SHALL NOT reset memory contents.
REQ-035 SHALL, when reset is asserted mid-operation, drop every in-flight read and emit no response for any of them after reset deasserts.

Verification
REQ-036 Single read: write 0xDEADBEEF at address 0x010 on ch0, then read address 0x010 with tag 0x5A at cycle T -> rsp_valid[0]=1 at T+2 with data 0xDEADBEEF and tag 0x5A.
REQ-037 Byte enable: word holds 0x11223344, write 0xAABBCCDD with byteen 4'b0101, then read -> 0x11BB33DD.
REQ-038 Backpressure: rsp_ready[1]=0 and 6 back-to-back reads on ch1 -> exactly 4 accepted, req_ready[1]=0 for the rest; release rsp_ready -> 4 responses in order, then req_ready[1] returns to 1.
REQ-039 Conflicts: same cycle, ch0 writes 0x1 and ch3 writes 0x3 to address 0x20 while ch2 reads 0x20 (old 0x0) -> ch2 returns 0x0; a later read returns 0x3.
REQ-040 Reset mid-flight: 3 reads outstanding on ch0, assert reset for 1 cycle -> no rsp_valid afterwards, req_ready=1, memory contents preserved.
REQ-041 Full throughput: all 4 channels issue reads every cycle with rsp_ready=1 -> 1 response per channel per cycle, tags in order.

Source files
------------

// File: rtl/vx_tex_mem_responder.sv
// Multi-channel word memory that answers texture-cache reads after a fixed latency.
// Each channel owns a read pipeline, a response FIFO and an outstanding-read limiter.

module vx_tex_mem_lane #(
  parameter int TAG_WIDTH  = 8,
  parameter int LATENCY    = 2,
  parameter int QUEUE_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 acc_rd,
  input  logic [31:0]          rd_word,
  input  logic [TAG_WIDTH-1:0] rd_tag,
  input  logic                 req_rw,
  output logic                 ready,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_data,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  input  logic                 rsp_ready
);
  localparam int PW = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam int CW = $clog2(QUEUE_SIZE + 1);

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          data;
  } entry_t;

  logic   [LATENCY:1] vld_pipe, vld_nxt;
  entry_t [LATENCY:1] ent_pipe, ent_nxt;
  entry_t             ent_in, head;
  entry_t             fifo [QUEUE_SIZE];
  logic   [PW-1:0]    wr_ptr, rd_ptr;
  logic   [CW-1:0]    count, pending;
  logic               fifo_empty, tail_vld, fire, push, pop;

  assign ent_in = '{tag: rd_tag, data: rd_word};

  if (LATENCY == 1) begin : g_l1
    assign vld_nxt = acc_rd;
    assign ent_nxt = ent_in;
  end else begin : g_ln
    assign vld_nxt = {vld_pipe[LATENCY-1:1], acc_rd};
    assign ent_nxt = {ent_pipe[LATENCY-1:1], ent_in};
  end

  assign fifo_empty = (count == '0);
  assign tail_vld   = vld_pipe[LATENCY];
  // With an empty FIFO the pipeline tail is presented directly, giving exact LATENCY.
  assign head      = fifo_empty ? ent_pipe[LATENCY] : fifo[rd_ptr];
  assign rsp_valid = ~reset & (~fifo_empty | tail_vld);
  assign rsp_data  = head.data;
  assign rsp_tag   = head.tag;
  assign fire      = rsp_valid & rsp_ready;
  assign push      = tail_vld & ~(fifo_empty & rsp_ready);
  assign pop       = fire & ~fifo_empty;
  // Pending covers pipeline plus FIFO, so a read is only taken when a slot is guaranteed.
  assign ready     = reset | req_rw | (pending < CW'(QUEUE_SIZE));

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
    end else begin
      vld_pipe <= vld_nxt;
      if (push) wr_ptr <= (wr_ptr == PW'(QUEUE_SIZE - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(QUEUE_SIZE - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (acc_rd & ~fire)      pending <= pending + 1'b1;
      else if (~acc_rd & fire) pending <= pending - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    ent_pipe <= ent_nxt;
    if (push) fifo[wr_ptr] <= ent_pipe[LATENCY];
  end
endmodule

module vx_tex_mem_responder #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int TAG_WIDTH  = 8,
  parameter int LATENCY    = 2,
  parameter int QUEUE_SIZE = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQS-1:0]                  req_valid,
  input  logic [NUM_REQS-1:0]                  req_rw,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQS-1:0][3:0]             req_byteen,
  input  logic [NUM_REQS-1:0][31:0]            req_data,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   req_tag,
  output logic [NUM_REQS-1:0]                  req_ready,
  output logic [NUM_REQS-1:0]                  rsp_valid,
  output logic [NUM_REQS-1:0][31:0]            rsp_data,
  output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   rsp_tag,
  input  logic [NUM_REQS-1:0]                  rsp_ready
);
  localparam int MEM_WORDS = 2 ** ADDR_WIDTH;

  logic [31:0]               mem [MEM_WORDS];
  logic [NUM_REQS-1:0]       wr_en, acc_rd;
  logic [NUM_REQS-1:0][31:0] rd_word;

  assign wr_en  = req_valid & req_rw & req_ready & ~{NUM_REQS{reset}};
  assign acc_rd = req_valid & ~req_rw & req_ready & ~{NUM_REQS{reset}};

  // Later channels overwrite earlier ones, so the highest index wins per byte.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_REQS; c++)
      for (int b = 0; b < 4; b++)
        if (wr_en[c] && req_byteen[c][b])
          mem[req_addr[c]][b*8 +: 8] <= req_data[c][b*8 +: 8];
  end

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    // Asynchronous read before the edge yields the pre-write word.
    assign rd_word[i] = mem[req_addr[i]];

    vx_tex_mem_lane #(
      .TAG_WIDTH (TAG_WIDTH),
      .LATENCY   (LATENCY),
      .QUEUE_SIZE(QUEUE_SIZE)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .acc_rd   (acc_rd[i]),
      .rd_word  (rd_word[i]),
      .rd_tag   (req_tag[i]),
      .req_rw   (req_rw[i]),
      .ready    (req_ready[i]),
      .rsp_valid(rsp_valid[i]),
      .rsp_data (rsp_data[i]),
      .rsp_tag  (rsp_tag[i]),
      .rsp_ready(rsp_ready[i])
    );
  end
endmodule

// File: tb/tb_vx_tex_mem_responder.sv
// Directed bench: stimulus pushes expected read responses, a negedge monitor pops and compares.
module tb_vx_tex_mem_responder;
  localparam int N = 4, AW = 12, TW = 8;

  logic                   clk = 1'b0, reset;
  logic [N-1:0]           req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][3:0]      req_byteen;
  logic [N-1:0][31:0]     req_data, rsp_data;
  logic [N-1:0][TW-1:0]   req_tag, rsp_tag;

  vx_tex_mem_responder #(.NUM_REQS(N), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .LATENCY(2), .QUEUE_SIZE(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   d;
    logic [TW-1:0] t;
  } exp_t;

  exp_t sb [N][$];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops plus stability while stalled.
  logic          hold [N];
  logic [31:0]   hd   [N];
  logic [TW-1:0] ht   [N];
  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (reset) begin
        hold[c] = 1'b0;
      end else begin
        if (hold[c]) begin
          chk($sformatf("hold_valid ch%0d", c), rsp_valid[c], 1'b1);
          chk($sformatf("hold_data ch%0d", c), rsp_data[c], hd[c]);
          chk($sformatf("hold_tag ch%0d", c), rsp_tag[c], ht[c]);
        end
        if (rsp_valid[c] && rsp_ready[c]) begin
          if (sb[c].size() == 0) chk($sformatf("unexpected_rsp ch%0d", c), 1, 0);
          else begin
            exp_t e;
            e = sb[c].pop_front();
            chk($sformatf("rsp_data ch%0d", c), rsp_data[c], e.d);
            chk($sformatf("rsp_tag ch%0d", c), rsp_tag[c], e.t);
          end
        end
        hold[c] = rsp_valid[c] & ~rsp_ready[c];
        hd[c]   = rsp_data[c];
        ht[c]   = rsp_tag[c];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_rw    = '0;
  endtask

  task automatic drv(input int c, input logic rw, input logic [AW-1:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [TW-1:0] t);
    req_valid[c]  = 1'b1;
    req_rw[c]     = rw;
    req_addr[c]   = a;
    req_data[c]   = d;
    req_byteen[c] = be;
    req_tag[c]    = t;
  endtask

  task automatic rd_exp(input int c, input logic [AW-1:0] a, input logic [TW-1:0] t, input logic [31:0] d);
    drv(c, 1'b0, a, 32'h0, 4'h0, t);
    sb[c].push_back('{d: d, t: t});
  endtask

  initial begin
    reset = 1'b1; rsp_ready = '1; idle();
    req_addr = '0; req_data = '0; req_byteen = '0; req_tag = '0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_req_ready", req_ready, 4'hF);
    chk("reset_rsp_valid", rsp_valid, 4'h0);
    step();
    reset = 1'b0;
    step();

    // single read with exact latency
    drv(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 8'h00); step(); idle();
    rd_exp(0, 12'h010, 8'h5A, 32'hDEADBEEF); step(); idle();
    @(negedge clk); chk("latency_t1", rsp_valid[0], 1'b0);
    step();
    @(negedge clk); chk("latency_t2", rsp_valid[0], 1'b1);
    step();

    // byte enables
    drv(0, 1'b1, 12'h011, 32'h11223344, 4'hF, 8'h00); step(); idle();
    drv(0, 1'b1, 12'h011, 32'hAABBCCDD, 4'b0101, 8'h00); step(); idle();
    rd_exp(0, 12'h011, 8'h22, 32'h11BB33DD); step(); idle();
    repeat (3) step();

    // backpressure: only QUEUE_SIZE reads outstanding
    rsp_ready[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k < 4) rd_exp(1, 12'h010, 8'(8'h30 + k), 32'hDEADBEEF);
      else       drv(1, 1'b0, 12'h010, 32'h0, 4'h0, 8'(8'h30 + k));
      @(negedge clk); chk($sformatf("bp_ready k%0d", k), req_ready[1], (k < 4));
      step();
    end
    idle();
    repeat (4) step();
    @(negedge clk);
    chk("bp_stalled_valid", rsp_valid[1], 1'b1);
    chk("bp_stalled_ready", req_ready[1], 1'b0);
    step();
    rsp_ready[1] = 1'b1;
    repeat (6) step();
    @(negedge clk); chk("bp_ready_back", req_ready[1], 1'b1);
    step();

    // same-cycle conflicts
    drv(0, 1'b1, 12'h020, 32'h0, 4'hF, 8'h00); step(); idle();
    drv(0, 1'b1, 12'h020, 32'h1, 4'hF, 8'h00);
    drv(3, 1'b1, 12'h020, 32'h3, 4'hF, 8'h00);
    rd_exp(2, 12'h020, 8'h44, 32'h0); step(); idle();
    rd_exp(2, 12'h020, 8'h45, 32'h3);
    rd_exp(1, 12'h020, 8'h46, 32'h3); step(); idle();
    repeat (4) step();

    // reset with reads in flight
    rsp_ready[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle(); drv(0, 1'b0, 12'h010, 32'h0, 4'h0, 8'(8'h70 + k)); step();
    end
    idle(); step();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 4'h0);
    chk("midrst_req_ready", req_ready, 4'hF);
    step();
    reset = 1'b0; rsp_ready[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); chk($sformatf("postrst_quiet k%0d", k), rsp_valid[0], 1'b0);
      step();
    end
    @(negedge clk); chk("postrst_ready", req_ready[0], 1'b1);
    step();
    rd_exp(0, 12'h010, 8'h77, 32'hDEADBEEF); step(); idle();
    repeat (3) step();

    // full throughput on all channels
    for (int k = 0; k < 8; k++) begin
      idle();
      for (int c = 0; c < N; c++)
        rd_exp(c, (k % 2) ? 12'h011 : 12'h010, 8'(c * 16 + k), (k % 2) ? 32'h11BB33DD : 32'hDEADBEEF);
      @(negedge clk);
      chk($sformatf("tp_ready k%0d", k), req_ready, 4'hF);
      if (k >= 2) chk($sformatf("tp_valid k%0d", k), rsp_valid, 4'hF);
      step();
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); chk($sformatf("tp_tail k%0d", k), rsp_valid, 4'hF);
      step();
    end
    @(negedge clk); chk("tp_done", rsp_valid, 4'h0);
    step();

    begin
      int w = 0;
      while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && w < 50) begin
        step(); w++;
      end
    end
    for (int c = 0; c < N; c++) chk($sformatf("sb_drain ch%0d", c), sb[c].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
